tlb_pipe: RTL

Parametrised, registered-output successor of the combinational MMU TLB. It provides two pipelined search ports (fetch and load/store), a registered read port and a write port with a round-robin fill pointer for TLBFILL. It also has an INVTLB engine with dedicated ASID/VA operands. It sits between the IF/MEM address-translation stages and the CSR/TLB-instruction unit.

---
 rtl/tlb_pipe.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_pipe.sv
// Pipelined TLB: two latency-1 search ports, registered read port, write port with
// round-robin fill pointer and a single-cycle INVTLB engine.
module tlb_pipe #(
  parameter int unsigned TLBNUM = 16,
  localparam int unsigned IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            s0_req,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_rsp_valid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  input  logic            s1_req,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_rsp_valid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            we,
  input  logic            w_fill,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_mat0,
  input  logic            w_d0,
  input  logic            w_v0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat1,
  input  logic            w_d1,
  input  logic            w_v1,
  output logic [IDXW-1:0] fill_index,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_mat0,
  output logic            r_d0,
  output logic            r_v0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat1,
  output logic            r_d1,
  output logic            r_v1,
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic            inv_err
);

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic        ps4;
    logic [9:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } entry_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [5:0]      ps;
    page_t           pg;
  } srch_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } rd_t;

  logic [TLBNUM-1:0] e_q, e_d;
  entry_t            ent_q [TLBNUM];
  entry_t            w_ent, r_ent;
  logic [IDXW-1:0]   fill_q, w_tgt;
  srch_t             s0_res, s1_res, s0_q, s1_q;
  logic              s0_vld_q, s1_vld_q;
  rd_t               r_q;
  logic              inv_err_q;

  function automatic logic va_hit(input entry_t ent, input logic [18:0] vppn);
    return (ent.vppn[18:9] == vppn[18:9]) && (ent.ps4 || (ent.vppn[8:0] == vppn[8:0]));
  endfunction

  function automatic logic srch_hit(input entry_t ent, input logic e, input logic [18:0] vppn,
                                    input logic [9:0] asid);
    return e && va_hit(ent, vppn) && (ent.g || (ent.asid == asid));
  endfunction

  function automatic srch_t hit_info(input entry_t ent, input int idx, input logic [18:0] vppn,
                                     input logic bit12);
    srch_t res;
    res.found = 1'b1;
    res.index = IDXW'(idx);
    res.ps    = ent.ps4 ? 6'd21 : 6'd12;
    res.pg    = (ent.ps4 ? vppn[8] : bit12) ? ent.p1 : ent.p0;
    return res;
  endfunction

  function automatic logic inv_hit(input entry_t ent, input logic [4:0] op,
                                   input logic [9:0] asid, input logic [18:0] vppn);
    logic am, vm, hit;
    am = (ent.asid == asid);
    vm = va_hit(ent, vppn);
    case (op)
      5'd0, 5'd1: hit = 1'b1;
      5'd2:       hit = ent.g;
      5'd3:       hit = !ent.g;
      5'd4:       hit = !ent.g && am;
      5'd5:       hit = !ent.g && am && vm;
      5'd6:       hit = (ent.g || am) && vm;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign w_tgt = w_fill ? fill_q : w_index;
  assign r_ent = ent_q[r_index];

  always_comb begin
    w_ent = '{vppn: w_vppn, ps4: (w_ps == 6'd21), asid: w_asid, g: w_g,
              p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
              p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};
  end

  // Walk from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    s0_res = '0;
    s1_res = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (srch_hit(ent_q[i], e_q[i], s0_vppn, s0_asid)) begin
        s0_res = hit_info(ent_q[i], i, s0_vppn, s0_va_bit12);
      end
      if (srch_hit(ent_q[i], e_q[i], s1_vppn, s1_asid)) begin
        s1_res = hit_info(ent_q[i], i, s1_vppn, s1_va_bit12);
      end
    end
  end

  // A write in the same cycle wins and the invalidate is dropped.
  always_comb begin
    e_d = e_q;
    if (we) begin
      e_d[w_tgt] = w_e;
    end else if (inv_valid) begin
      for (int i = 0; i < int'(TLBNUM); i++) begin
        if (inv_hit(ent_q[i], inv_op, inv_asid, inv_vppn)) e_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q       <= '0;
      fill_q    <= '0;
      s0_vld_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      r_q       <= '0;
      inv_err_q <= 1'b0;
    end else begin
      e_q      <= e_d;
      if (we && w_fill) fill_q <= fill_q + IDXW'(1);
      s0_vld_q <= s0_req;
      s1_vld_q <= s1_req;
      s0_q     <= s0_req ? s0_res : '0;
      s1_q     <= s1_req ? s1_res : '0;
      r_q      <= '{e: e_q[r_index], vppn: r_ent.vppn, ps: (r_ent.ps4 ? 6'd21 : 6'd12),
                    asid: r_ent.asid, g: r_ent.g, p0: r_ent.p0, p1: r_ent.p1};
      inv_err_q <= inv_valid && !we && (inv_op > 5'd6);
    end
  end

  always_ff @(posedge clk) begin
    if (we) ent_q[w_tgt] <= w_ent;
  end

  assign s0_rsp_valid = s0_vld_q;
  assign s0_found     = s0_q.found;
  assign s0_index     = s0_q.index;
  assign s0_ppn       = s0_q.pg.ppn;
  assign s0_ps        = s0_q.ps;
  assign s0_plv       = s0_q.pg.plv;
  assign s0_mat       = s0_q.pg.mat;
  assign s0_d         = s0_q.pg.d;
  assign s0_v         = s0_q.pg.v;
  assign s1_rsp_valid = s1_vld_q;
  assign s1_found     = s1_q.found;
  assign s1_index     = s1_q.index;
  assign s1_ppn       = s1_q.pg.ppn;
  assign s1_ps        = s1_q.ps;
  assign s1_plv       = s1_q.pg.plv;
  assign s1_mat       = s1_q.pg.mat;
  assign s1_d         = s1_q.pg.d;
  assign s1_v         = s1_q.pg.v;

  assign fill_index = fill_q;

  assign r_e    = r_q.e;
  assign r_vppn = r_q.vppn;
  assign r_ps   = r_q.ps;
  assign r_asid = r_q.asid;
  assign r_g    = r_q.g;
  assign r_ppn0 = r_q.p0.ppn;
  assign r_plv0 = r_q.p0.plv;
  assign r_mat0 = r_q.p0.mat;
  assign r_d0   = r_q.p0.d;
  assign r_v0   = r_q.p0.v;
  assign r_ppn1 = r_q.p1.ppn;
  assign r_plv1 = r_q.p1.plv;
  assign r_mat1 = r_q.p1.mat;
  assign r_d1   = r_q.p1.d;
  assign r_v1   = r_q.p1.v;

  assign inv_err = inv_err_q;

endmodule
